// File: rtl/rom_bus_pkg.sv
// Shared constants for the program-ROM bus: ROM geometry and requester port indices.
package rom_bus_pkg;
  localparam int ROM_ADDR_WIDTH = 11;
  localparam int ROM_DATA_WIDTH = 16;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;
endpackage

// File: rtl/rom_rr_pick.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
module rom_rr_pick
  import rom_bus_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       last_gnt,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    winner = PORT_FETCH;
    valid  = 1'b0;
    case (elig)
      2'b01: begin
        winner = PORT_FETCH;
        valid  = 1'b1;
      end
      2'b10: begin
        winner = PORT_DATA;
        valid  = 1'b1;
      end
      2'b11: begin
        winner = ~last_gnt;
        valid  = 1'b1;
      end
      default: begin
        winner = PORT_FETCH;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the registered-read program ROM between instruction fetch (port 0) and
// operand read (port 1); each port has one outstanding read and a held response.
module rom_arbiter
  import rom_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int DATA_WIDTH = ROM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  output logic                  gnt_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic                  rvalid_0,
  input  logic                  rready_0,
  input  logic                  req_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  output logic                  gnt_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  rvalid_1,
  input  logic                  rready_1,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  logic [1:0]            req;
  logic [1:0]            rready;
  logic [1:0]            busy;
  logic [1:0]            elig;
  logic [1:0]            gnt;
  logic [1:0]            rvalid;
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic                  pick_port;
  logic                  pick_valid;
  logic                  last_gnt;
  logic                  issue_valid;
  logic                  issue_port;
  logic [ADDR_WIDTH-1:0] addr_hold;

  assign req    = {req_1, req_0};
  assign rready = {rready_1, rready_0};
  assign elig   = req & ~busy;

  rom_rr_pick u_pick (
    .elig     (elig),
    .last_gnt (last_gnt),
    .winner   (pick_port),
    .valid    (pick_valid)
  );

  // ROM address follows the winner combinationally, otherwise parks on the last issued address
  always_comb begin
    gnt         = 2'b00;
    rom_address = addr_hold;
    if (pick_valid) begin
      gnt[pick_port] = 1'b1;
      rom_address    = (pick_port == PORT_DATA) ? addr_1 : addr_0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_hold   <= '0;
      last_gnt    <= PORT_DATA;
      issue_valid <= 1'b0;
      issue_port  <= PORT_FETCH;
    end else begin
      issue_valid <= pick_valid;
      if (pick_valid) begin
        addr_hold  <= rom_address;
        last_gnt   <= pick_port;
        issue_port <= pick_port;
      end
    end
  end

  // Capture and acceptance never collide on one port: busy blocks a re-grant until acceptance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 2'b00;
      rvalid  <= 2'b00;
      rdata_q <= '{default: '0};
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (gnt[p]) begin
          busy[p] <= 1'b1;
        end else if (rvalid[p] && rready[p]) begin
          busy[p] <= 1'b0;
        end

        if (issue_valid && (int'(issue_port) == p)) begin
          rvalid[p]  <= 1'b1;
          rdata_q[p] <= rom_data;
        end else if (rvalid[p] && rready[p]) begin
          rvalid[p] <= 1'b0;
        end
      end
    end
  end

  assign gnt_0    = gnt[0];
  assign gnt_1    = gnt[1];
  assign rvalid_0 = rvalid[0];
  assign rvalid_1 = rvalid[1];
  assign rdata_0  = rdata_q[0];
  assign rdata_1  = rdata_q[1];

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: ROM model, directed scenarios and random traffic checked
// against a transaction-level model (grant rules plus fixed two-cycle response latency).
module tb_rom_arbiter;
  import rom_bus_pkg::*;

  localparam int AW = ROM_ADDR_WIDTH;
  localparam int DW = ROM_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_0 = 1'b0, req_1 = 1'b0;
  logic          rready_0 = 1'b0, rready_1 = 1'b0;
  logic [AW-1:0] addr_0 = '0, addr_1 = '0;
  logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [DW-1:0] rdata_0, rdata_1;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] mem [2**AW];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_address];

  rom_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_0       (req_0),
    .addr_0      (addr_0),
    .gnt_0       (gnt_0),
    .rdata_0     (rdata_0),
    .rvalid_0    (rvalid_0),
    .rready_0    (rready_0),
    .req_1       (req_1),
    .addr_1      (addr_1),
    .gnt_1       (gnt_1),
    .rdata_1     (rdata_1),
    .rvalid_1    (rvalid_1),
    .rready_1    (rready_1),
    .rom_address (rom_address),
    .rom_data    (rom_data)
  );

  // transaction-level reference state
  bit            m_busy [2];
  int            m_due  [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_data [2];
  int            m_last;
  int            m_lastw;
  logic [AW-1:0] m_hold;
  int            cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_busy[p] = 1'b0;
      m_due[p]  = -1;
      m_addr[p] = '0;
      m_data[p] = '0;
    end
    m_last  = 1;
    m_lastw = -1;
    m_hold  = '0;
  endtask

  // called at posedge+1; leaves at the next posedge+1
  task automatic apply_reset();
    req_0 = 1'b0; req_1 = 1'b0; rready_0 = 1'b0; rready_1 = 1'b0;
    addr_0 = '0; addr_1 = '0;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_gnt_0", gnt_0, 0);
    chk("rst_gnt_1", gnt_1, 0);
    chk("rst_rvalid_0", rvalid_0, 0);
    chk("rst_rvalid_1", rvalid_1, 0);
    chk("rst_rdata_0", rdata_0, 0);
    chk("rst_rdata_1", rdata_1, 0);
    chk("rst_rom_address", rom_address, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc++;
  endtask

  task automatic step(input logic r0, input logic [AW-1:0] a0, input logic y0,
                      input logic r1, input logic [AW-1:0] a1, input logic y1);
    logic [AW-1:0] ad [2];
    bit            rq [2];
    bit            ry [2];
    bit            rv [2];
    int            w;
    req_0 = r0; addr_0 = a0; rready_0 = y0;
    req_1 = r1; addr_1 = a1; rready_1 = y1;
    ad[0] = a0; ad[1] = a1;
    rq[0] = r0; rq[1] = r1;
    ry[0] = y0; ry[1] = y1;
    #2;
    w = -1;
    if (rq[0] && !m_busy[0] && rq[1] && !m_busy[1]) w = 1 - m_last;
    else if (rq[0] && !m_busy[0]) w = 0;
    else if (rq[1] && !m_busy[1]) w = 1;
    for (int p = 0; p < 2; p++) begin
      if (m_due[p] == cyc) m_data[p] = mem[m_addr[p]];
      rv[p] = (m_due[p] >= 0) && (cyc >= m_due[p]);
    end
    chk("gnt_0", gnt_0, 32'(w == 0));
    chk("gnt_1", gnt_1, 32'(w == 1));
    chk("rom_address", rom_address, (w >= 0) ? ad[w] : m_hold);
    chk("rvalid_0", rvalid_0, 32'(rv[0]));
    chk("rvalid_1", rvalid_1, 32'(rv[1]));
    chk("rdata_0", rdata_0, m_data[0]);
    chk("rdata_1", rdata_1, m_data[1]);
    for (int p = 0; p < 2; p++) begin
      if (rv[p] && ry[p]) begin
        m_due[p]  = -1;
        m_busy[p] = 1'b0;
      end
    end
    if (w >= 0) begin
      m_busy[w] = 1'b1;
      m_due[w]  = cyc + 2;
      m_addr[w] = ad[w];
      m_last    = w;
      m_hold    = ad[w];
    end
    m_lastw = w;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
  endtask

  bit            s_req  [2];
  logic [AW-1:0] s_addr [2];
  bit            s_rdy  [2];

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
    mem[11'h005] = 16'h1234;
    mem[11'h010] = 16'hAAAA;
    mem[11'h020] = 16'h5555;
    mem[11'h7FF] = 16'hBEEF;

    apply_reset();
    idle(3);

    // single port 0, rready high
    step(1'b1, 11'h005, 1'b1, 1'b0, '0, 1'b1);
    chk("single_gnt_seen", 32'(m_lastw), 0);
    step(1'b0, 11'h005, 1'b1, 1'b0, '0, 1'b1);
    chk("single_rvalid_t2", rvalid_0, 1);
    chk("single_rdata_t2", rdata_0, 16'h1234);
    for (int i = 0; i < 7; i++) step(1'b1, 11'h005, 1'b1, 1'b0, '0, 1'b1);
    idle(3);

    // reset while a read is in flight
    step(1'b1, 11'h005, 1'b1, 1'b0, '0, 1'b1);
    apply_reset();
    idle(4);

    // tie: port 0 must win first after reset, then alternate
    for (int i = 0; i < 12; i++) step(1'b1, 11'h010, 1'b1, 1'b1, 11'h020, 1'b1);
    idle(3);

    // backpressure on port 1
    step(1'b0, '0, 1'b1, 1'b1, 11'h020, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 11'h010, 1'b1, 1'b1, 11'h020, 1'b0);
    chk("bp_rvalid_1", rvalid_1, 1);
    chk("bp_rdata_1", rdata_1, 16'h5555);
    step(1'b0, '0, 1'b1, 1'b0, 11'h020, 1'b1);
    chk("bp_release_rvalid_1", rvalid_1, 0);
    idle(4);

    // withdraw: make port 1 the last winner, then pulse req_1 while port 0 wins
    step(1'b0, '0, 1'b1, 1'b1, 11'h020, 1'b1);
    idle(3);
    step(1'b1, 11'h010, 1'b1, 1'b1, 11'h020, 1'b1);
    idle(4);
    chk("withdraw_rvalid_1", rvalid_1, 0);
    step(1'b1, 11'h010, 1'b1, 1'b1, 11'h020, 1'b1);
    idle(3);

    // address boundary: last word then word 0, then park
    step(1'b1, 11'h7FF, 1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 11'h000, 1'b1, 1'b0, '0, 1'b1);
    chk("boundary_rdata_7ff", rdata_0, 16'hBEEF);
    step(1'b1, 11'h000, 1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 11'h000, 1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 11'h123, 1'b1, 1'b0, 11'h456, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 11'h123, 1'b1, 1'b0, 11'h456, 1'b1);
      chk("boundary_idle_rom_address", rom_address, 0);
    end

    // random traffic
    for (int p = 0; p < 2; p++) begin
      s_req[p] = 1'b0;
      s_addr[p] = '0;
      s_rdy[p] = 1'b1;
    end
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (s_req[p] && m_lastw != p) begin
          if ($urandom_range(9) == 0) s_req[p] = 1'b0;
        end else begin
          s_req[p]  = ($urandom_range(9) < 6);
          s_addr[p] = AW'($urandom_range(2**AW - 1));
        end
        s_rdy[p] = ($urandom_range(9) < 7);
      end
      step(s_req[0], s_addr[0], s_rdy[0], s_req[1], s_addr[1], s_rdy[1]);
      if (i == 300) apply_reset();
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single synchronous program ROM (2048 x 16, one-cycle registered read) between two requesters: port 0 = instruction fetch, port 1 = operand/data read.
- Round-robin arbitration with a grant pulse per request.
- Tracks the in-flight read through the ROM latency and holds each port's response in a per-port register until that port accepts it.
- Sits between the F100-L core's fetch/execute units and the rom instance.

Parameters:
- ADDR_WIDTH, 11: ROM word address width (2048 words).
- DATA_WIDTH, 16: ROM word width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_0  input  1  port 0 read request; held with addr_0 stable until gnt_0.
- addr_0  input  ADDR_WIDTH  port 0 word address.
- gnt_0  output  1  combinational; request accepted this cycle.
- rdata_0  output  DATA_WIDTH  port 0 read data.
- rvalid_0  output  1  rdata_0 valid; held until rready_0.
- rready_0  input  1  port 0 consumes response.
- req_1, addr_1, gnt_1, rdata_1, rvalid_1, rready_1: same as port 0, for port 1.
- rom_address  output  ADDR_WIDTH  drives the ROM address input.
- rom_data  input  DATA_WIDTH  ROM data_out, valid the cycle after the address was sampled.

Behaviour:
- Reset (async, any time including mid-read):
  - gnt_x=0, rvalid_x=0, rdata_x=0, rom_address=0.
  - busy_0=busy_1=0, issue_valid=0, last_gnt=1 (so port 0 wins the first tie).
  - Any in-flight read is discarded and never returned.
- Eligibility: port x eligible = req_x & ~busy_x.
  - busy_x sets on the cycle gnt_x=1.
  - busy_x clears on the cycle rvalid_x & rready_x.
  - Each port has at most one outstanding read.
- Arbitration (combinational, cycle t):
  - One eligible port: that port wins.
  - Both eligible: the port != last_gnt wins.
  - Neither eligible: no grant.
  - At most one gnt_x high per cycle.
- Issue, cycle t with a winner w:
  - gnt_w=1.
  - rom_address=addr_w combinationally.
  - Registered at edge: addr_hold<=addr_w, last_gnt<=w, issue_valid<=1, issue_port<=w.
- No winner: rom_address=addr_hold, issue_valid<=0.
- Data, cycle t+1:
  - rom_data holds mem[addr_w].
  - If issue_valid, then at edge end of t+1: rdata_{issue_port}<=rom_data, rvalid_{issue_port}<=1.
- Response, cycle t+2: rvalid_w=1. Fixed latency gnt→rvalid = 2 cycles.
- Hold:
  - rvalid_x and rdata_x stay stable while rready_x=0.
  - rvalid_x clears at the edge where rvalid_x & rready_x.
  - rdata_x keeps its last value after clearing.
- rready_x while rvalid_x=0: ignored.
- Throughput:
  - Pipelined across ports; one grant per cycle total.
  - A single port with rready tied high: grant at t, rvalid at t+2, eligible again at t+3.
- Simultaneous events:
  - A capture into port x never coincides with rvalid_x already high, because busy_x blocks re-grant.
  - Port x acceptance and port y capture in the same cycle are independent.
- req_x deasserted with no grant: the request is withdrawn, no side effects.
- req_x held after gnt_x: treated as a new request once busy_x clears.
- Addresses are used unmodified; no wrap logic. ADDR_WIDTH bits index the full ROM.

Decomposition:
- Shared package rom_bus_pkg:
  - constants ROM_ADDR_WIDTH=11, ROM_DATA_WIDTH=16;
  - port index constants PORT_FETCH=0, PORT_DATA=1.
- Optional sub-module rom_rr_pick: 2-way round-robin picker (elig[1:0], last_gnt → winner, valid). It is purely combinational, reusable for later bus arbiters.
- The response registers stay inline.

Test Plan:
- Reset then idle:
  - all outputs 0;
  - assert reset_n=0 mid-read (gnt at t, reset at t+1) → no rvalid ever appears for that read; next tie grants port 0.
- Single port 0: req_0 with addr_0=0x005, ROM[5]=0x1234, rready_0=1 → gnt_0 at t, rvalid_0=1 with rdata_0=0x1234 at t+2 for one cycle, next gnt_0 no earlier than t+3.
- Tie:
  - Setup: both req high continuously, addr_0=0x010 (0xAAAA), addr_1=0x020 (0x5555), rready high.
  - Required grant order: 0,1,0,1…
  - rdata_0=0xAAAA, rdata_1=0x5555, each 2 cycles after its grant.
- Backpressure:
  - Setup: port 1 granted, rready_1=0 for 5 cycles.
  - Required: rvalid_1 and rdata_1 held stable; port 1 is not re-granted; port 0 requests still served every 3 cycles.
  - Release rready_1 → rvalid_1 drops at next edge.
- Withdraw: req_1 pulsed for one cycle while port 0 wins → no gnt_1, no rvalid_1, last_gnt unaffected by port 1.
- Address boundary: addr_0=0x7FF (ROM last word=0xBEEF) then 0x000 → correct data in order; rom_address holds 0x000 during following idle cycles.
